sram_arbiter: RTL and testbench

- Shares the single sram_interface between two requesters: port 0 is the sensor logger (mostly writes); port 1 is telemetry readback (mostly reads).
- Arbitrates, issues one CMD per transaction, follows the STATUS busy handshake, returns read data and a one-cycle ACK.
- Sits between the logging/telemetry blocks and sram_interface, and is its only driver.

---
 rtl/sram_arbiter_pkg.sv | 16 +
 rtl/sram_rr_select.sv | 15 +
 rtl/sram_arbiter.sv | 115 +++++++++++
 tb/tb_sram_arbiter.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/sram_arbiter_pkg.sv
// sram_arbiter_pkg: shared widths, SRAM command codes and arbiter FSM states
package sram_arbiter_pkg;
  localparam int ADDR_W = 19;
  localparam int DATA_W = 16;
  typedef enum logic [1:0] {
    CMD_IDLE  = 2'd0,
    CMD_READ  = 2'd1,
    CMD_WRITE = 2'd2
  } cmd_e;
  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_BUSY = 2'd1,
    ST_WAIT_DONE = 2'd2,
    ST_DONE      = 2'd3
  } state_e;
endpackage

// File: rtl/sram_rr_select.sv
// sram_rr_select: combinational 2-way picker, round-robin on the last winner or fixed port-0 priority
module sram_rr_select (
  input  logic i_req0,
  input  logic i_req1,
  input  logic i_ptr,
  input  logic i_fixed_pri,
  output logic o_grant_valid,
  output logic o_grant_id
);
  // i_ptr is the last winner, so a contended grant goes to the other port
  always_comb begin
    o_grant_valid = i_req0 | i_req1;
    o_grant_id    = i_fixed_pri ? !i_req0 : (i_req0 & i_req1) ? !i_ptr : i_req1;
  end
endmodule

// File: rtl/sram_arbiter.sv
// sram_arbiter: shares one sram_interface between the logger (port 0) and telemetry (port 1),
// issuing a one-cycle CMD per transaction and tracking the falling-edge STATUS busy handshake.
module sram_arbiter
  import sram_arbiter_pkg::*;
#(
  parameter int TIMEOUT   = 8,
  parameter bit FIXED_PRI = 1'b0
) (
  input  logic                CLK_48MHZ,
  input  logic                RESET,
  input  logic                REQ0,
  input  logic                REQ1,
  input  logic                WE0,
  input  logic                WE1,
  input  logic [ADDR_W-1:0]   ADDR0,
  input  logic [ADDR_W-1:0]   ADDR1,
  input  logic [DATA_W-1:0]   WDATA0,
  input  logic [DATA_W-1:0]   WDATA1,
  output logic                ACK0,
  output logic                ACK1,
  output logic [DATA_W-1:0]   RDATA0,
  output logic [DATA_W-1:0]   RDATA1,
  output logic                ERR0,
  output logic                ERR1,
  output logic [1:0]          SRAM_CMD,
  output logic [ADDR_W-2:0]   SRAM_ADDRESS,
  output logic                SRAM_CHIP_SELECT,
  output logic [DATA_W-1:0]   SRAM_DATA_OUT,
  input  logic                SRAM_STATUS,
  input  logic [DATA_W-1:0]   SRAM_DATA_READ,
  output logic                TIMEOUT_SEEN
);
  localparam int CW = $clog2(TIMEOUT + 1);
  state_e            r_state, w_next;
  logic [CW-1:0]     r_cnt;
  logic              r_ptr, r_win, r_we, r_err;
  logic              w_grant_valid, w_grant_id;
  logic              w_accept, w_busy_seen, w_tmo, w_capture, w_done, w_we;
  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] w_wdata;
  sram_rr_select u_sel (
    .i_req0        (REQ0),
    .i_req1        (REQ1),
    .i_ptr         (r_ptr),
    .i_fixed_pri   (FIXED_PRI),
    .o_grant_valid (w_grant_valid),
    .o_grant_id    (w_grant_id)
  );
  always_ff @(posedge CLK_48MHZ or negedge RESET)
    if (!RESET) r_state <= ST_IDLE;
    else        r_state <= w_next;
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:      w_next = w_accept ? ST_WAIT_BUSY : ST_IDLE;
      ST_WAIT_BUSY: w_next = SRAM_STATUS ? ST_WAIT_DONE : w_tmo ? ST_DONE : ST_WAIT_BUSY;
      ST_WAIT_DONE: w_next = SRAM_STATUS ? ST_WAIT_DONE : ST_DONE;
      default:      w_next = ST_IDLE;
    endcase
  end
  // A busy STATUS seen in IDLE belongs to someone else, so issuing waits for it to clear
  always_comb begin
    w_accept    = (r_state == ST_IDLE) && w_grant_valid && !SRAM_STATUS;
    w_busy_seen = (r_state == ST_WAIT_BUSY) && SRAM_STATUS;
    w_tmo       = (r_state == ST_WAIT_BUSY) && !SRAM_STATUS && (r_cnt == CW'(TIMEOUT - 1));
    w_capture   = (r_state == ST_WAIT_DONE) && !SRAM_STATUS && !r_we;
    w_done      = (r_state == ST_DONE);
    w_we        = w_grant_id ? WE1 : WE0;
    w_addr      = w_grant_id ? ADDR1 : ADDR0;
    w_wdata     = w_grant_id ? WDATA1 : WDATA0;
  end
  always_ff @(posedge CLK_48MHZ or negedge RESET)
    if (!RESET) begin
      r_cnt            <= '0;
      r_ptr            <= 1'b0;
      r_win            <= 1'b0;
      r_we             <= 1'b0;
      r_err            <= 1'b0;
      ACK0             <= 1'b0;
      ACK1             <= 1'b0;
      ERR0             <= 1'b0;
      ERR1             <= 1'b0;
      RDATA0           <= '0;
      RDATA1           <= '0;
      SRAM_CMD         <= CMD_IDLE;
      SRAM_ADDRESS     <= '0;
      SRAM_CHIP_SELECT <= 1'b0;
      SRAM_DATA_OUT    <= '0;
      TIMEOUT_SEEN     <= 1'b0;
    end else begin
      ACK0 <= w_done && !r_win;
      ACK1 <= w_done && r_win;
      ERR0 <= w_done && !r_win && r_err;
      ERR1 <= w_done && r_win && r_err;
      if (w_accept) begin
        r_win            <= w_grant_id;
        r_ptr            <= w_grant_id;
        r_we             <= w_we;
        r_err            <= 1'b0;
        r_cnt            <= '0;
        SRAM_CMD         <= w_we ? CMD_WRITE : CMD_READ;
        SRAM_ADDRESS     <= w_addr[ADDR_W-1:1];
        SRAM_CHIP_SELECT <= w_addr[0];
        SRAM_DATA_OUT    <= w_wdata;
      end
      if ((r_state == ST_WAIT_BUSY) && !SRAM_STATUS) r_cnt <= r_cnt + 1'b1;
      if (w_busy_seen || w_tmo) SRAM_CMD <= CMD_IDLE;
      if (w_tmo) begin
        r_err        <= 1'b1;
        TIMEOUT_SEEN <= 1'b1;
      end
      if (w_capture && r_win)  RDATA1 <= SRAM_DATA_READ;
      if (w_capture && !r_win) RDATA0 <= SRAM_DATA_READ;
    end
endmodule

// File: tb/tb_sram_arbiter.sv
// tb_sram_arbiter: scoreboard bench; a round-robin and a fixed-priority arbiter each drive a falling-edge SRAM model.
module tb_sram_arbiter;
  typedef struct {
    int          port;
    bit          err;
    logic [15:0] rd;
  } exp_t;
  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;
  int tests = 0, fails = 0;
  exp_t qa[$], qb[$];
  logic        a_req0 = 0, a_req1 = 0, a_we0 = 0, a_we1 = 0;
  logic [18:0] a_addr0 = '0, a_addr1 = '0;
  logic [15:0] a_wd0 = '0, a_wd1 = '0;
  logic        a_ack0, a_ack1, a_err0, a_err1, a_cs, a_ts;
  logic [15:0] a_rd0, a_rd1, a_dout, a_drd;
  logic [1:0]  a_cmd;
  logic [17:0] a_sa;
  logic        a_st, a_force = 0, a_en = 1, a_stat, seeded = 0;
  int          a_bc;
  logic [15:0] mem [0:31];
  logic        b_req0 = 0, b_req1 = 0, b_we0 = 0, b_we1 = 0;
  logic [18:0] b_addr0 = '0, b_addr1 = '0;
  logic [15:0] b_wd0 = '0, b_wd1 = '0;
  logic        b_ack0, b_ack1, b_err0, b_err1, b_cs, b_ts, b_st;
  logic [15:0] b_rd0, b_rd1, b_dout;
  logic [1:0]  b_cmd;
  logic [17:0] b_sa;
  int          b_bc;
  assign a_stat = a_st | a_force;
  sram_arbiter #(.TIMEOUT(8), .FIXED_PRI(1'b0)) ua (
    .CLK_48MHZ(clk), .RESET(rst_n), .REQ0(a_req0), .REQ1(a_req1), .WE0(a_we0), .WE1(a_we1),
    .ADDR0(a_addr0), .ADDR1(a_addr1), .WDATA0(a_wd0), .WDATA1(a_wd1), .ACK0(a_ack0), .ACK1(a_ack1),
    .RDATA0(a_rd0), .RDATA1(a_rd1), .ERR0(a_err0), .ERR1(a_err1), .SRAM_CMD(a_cmd),
    .SRAM_ADDRESS(a_sa), .SRAM_CHIP_SELECT(a_cs), .SRAM_DATA_OUT(a_dout), .SRAM_STATUS(a_stat),
    .SRAM_DATA_READ(a_drd), .TIMEOUT_SEEN(a_ts));
  sram_arbiter #(.TIMEOUT(8), .FIXED_PRI(1'b1)) ub (
    .CLK_48MHZ(clk), .RESET(rst_n), .REQ0(b_req0), .REQ1(b_req1), .WE0(b_we0), .WE1(b_we1),
    .ADDR0(b_addr0), .ADDR1(b_addr1), .WDATA0(b_wd0), .WDATA1(b_wd1), .ACK0(b_ack0), .ACK1(b_ack1),
    .RDATA0(b_rd0), .RDATA1(b_rd1), .ERR0(b_err0), .ERR1(b_err1), .SRAM_CMD(b_cmd),
    .SRAM_ADDRESS(b_sa), .SRAM_CHIP_SELECT(b_cs), .SRAM_DATA_OUT(b_dout), .SRAM_STATUS(b_st),
    .SRAM_DATA_READ(16'h0000), .TIMEOUT_SEEN(b_ts));
  // sram_interface stand-in: busy one falling edge for a write, two for a read
  always @(negedge clk)
    if (!rst_n) begin
      a_st <= 1'b0;
      a_bc <= 0;
      if (!seeded) begin
        for (int i = 0; i < 32; i++) mem[i] <= (i == 4) ? 16'h1234 : 16'h0000;
        seeded <= 1'b1;
      end
    end else if (a_bc != 0) begin
      a_bc <= a_bc - 1;
      if (a_bc == 1) a_st <= 1'b0;
    end else if (a_en && a_cmd != 2'd0) begin
      a_st <= 1'b1;
      a_bc <= (a_cmd == 2'd2) ? 1 : 2;
      if (a_cmd == 2'd2) mem[{a_sa[3:0], a_cs}] <= a_dout;
      else a_drd <= mem[{a_sa[3:0], a_cs}];
    end
  always @(negedge clk)
    if (!rst_n) begin
      b_st <= 1'b0;
      b_bc <= 0;
    end else if (b_bc != 0) begin
      b_bc <= b_bc - 1;
      if (b_bc == 1) b_st <= 1'b0;
    end else if (b_cmd != 2'd0) begin
      b_st <= 1'b1;
      b_bc <= (b_cmd == 2'd2) ? 1 : 2;
    end
  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endfunction
  function automatic void chk_ack(input string t, input exp_t e, input logic k0, input logic k1,
                                  input logic e0, input logic e1, input logic [15:0] r0, input logic [15:0] r1);
    chk({t, "_both_ack"}, {31'b0, k0 & k1}, 0);
    chk({t, "_port"}, {31'b0, k1}, e.port);
    chk({t, "_err"}, {31'b0, k1 ? e1 : e0}, {31'b0, e.err});
    chk({t, "_err_other"}, {31'b0, k1 ? e0 : e1}, 0);
    chk({t, "_rdata"}, {16'b0, k1 ? r1 : r0}, {16'b0, e.rd});
  endfunction
  always @(negedge clk)
    if (rst_n && (a_ack0 || a_ack1)) begin
      if (qa.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL a_unexpected_ack: got ack0=%b ack1=%b expected no ack", a_ack0, a_ack1);
      end else chk_ack("a", qa.pop_front(), a_ack0, a_ack1, a_err0, a_err1, a_rd0, a_rd1);
    end
  always @(negedge clk)
    if (rst_n && (b_ack0 || b_ack1)) begin
      if (qb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL b_unexpected_ack: got ack0=%b ack1=%b expected no ack", b_ack0, b_ack1);
      end else chk_ack("b", qb.pop_front(), b_ack0, b_ack1, b_err0, b_err1, b_rd0, b_rd1);
    end
  task automatic push_a(input int p, input bit err, input logic [15:0] rd);
    exp_t e;
    e.port = p; e.err = err; e.rd = rd;
    qa.push_back(e);
  endtask
  task automatic push_b(input int p, input logic [15:0] rd);
    exp_t e;
    e.port = p; e.err = 1'b0; e.rd = rd;
    qb.push_back(e);
  endtask
  task automatic wait_a(output int n);
    n = 0;
    do begin @(posedge clk); #1; n++; end while (!(a_ack0 || a_ack1) && n < 20);
  endtask
  task automatic wait_b(output int n);
    n = 0;
    do begin @(posedge clk); #1; n++; end while (!(b_ack0 || b_ack1) && n < 20);
  endtask
  task automatic txn(input bit p, input bit we, input logic [18:0] a, input logic [15:0] wd,
                     input logic [15:0] rd, input bit err, input int lat);
    int n, cc;
    push_a(p, err, rd);
    if (p) begin a_req1 = 1; a_we1 = we; a_addr1 = a; a_wd1 = wd; end
    else   begin a_req0 = 1; a_we0 = we; a_addr0 = a; a_wd0 = wd; end
    @(posedge clk); #1;
    chk("cmd", {30'b0, a_cmd}, we ? 2 : 1);
    chk("sram_addr", {14'b0, a_sa}, {14'b0, a[18:1]});
    chk("chip_select", {31'b0, a_cs}, {31'b0, a[0]});
    if (we) chk("data_out", {16'b0, a_dout}, {16'b0, wd});
    cc = 1;
    n = 0;
    while (!(a_ack0 || a_ack1) && n < 20) begin
      @(posedge clk); #1; n++;
      if (a_cmd != 2'd0) cc++;
    end
    chk("latency", n, lat);
    chk("cmd_cycles", cc, err ? 8 : 1);
    if (p) a_req1 = 0; else a_req0 = 0;
  endtask
  task automatic chk_reset_outs();
    chk("rst_cmd", {30'b0, a_cmd}, 0);
    chk("rst_addr", {14'b0, a_sa}, 0);
    chk("rst_cs", {31'b0, a_cs}, 0);
    chk("rst_dout", {16'b0, a_dout}, 0);
    chk("rst_acks", {28'b0, a_ack0, a_ack1, a_err0, a_err1}, 0);
    chk("rst_rdata", {a_rd0, a_rd1}, 0);
    chk("rst_timeout_seen", {31'b0, a_ts}, 0);
  endtask
  initial begin
    int n, acks;
    repeat (2) @(posedge clk);
    #1 chk_reset_outs();
    chk("b_rst_cmd", {30'b0, b_cmd}, 0);
    rst_n = 1;
    txn(0, 1, 19'h00005, 16'hBEEF, 16'h0000, 0, 3);
    txn(1, 0, 19'h00004, 16'h0000, 16'h1234, 0, 4);
    txn(0, 1, 19'h00007, 16'h5A5A, 16'h0000, 0, 3);
    txn(1, 0, 19'h00007, 16'h0000, 16'h5A5A, 0, 4);
    txn(0, 0, 19'h00005, 16'h0000, 16'hBEEF, 0, 4);
    a_en = 0;
    txn(0, 1, 19'h00009, 16'h1111, 16'hBEEF, 1, 9);
    a_en = 1;
    chk("timeout_seen_set", {31'b0, a_ts}, 1);
    a_we0 = 1; a_addr0 = 19'h00010; a_wd0 = 16'h0A0A;
    a_we1 = 1; a_addr1 = 19'h00012; a_wd1 = 16'h1B1B;
    push_a(1, 0, 16'h5A5A); push_a(0, 0, 16'hBEEF); push_a(1, 0, 16'h5A5A); push_a(0, 0, 16'hBEEF);
    a_req0 = 1; a_req1 = 1;
    for (int k = 0; k < 4; k++) begin
      wait_a(n);
      chk("rr_gap", n, 4);
    end
    a_req0 = 0; a_req1 = 0;
    chk("timeout_seen_sticky", {31'b0, a_ts}, 1);
    b_we0 = 1; b_addr0 = 19'h00001; b_wd0 = 16'h0001;
    b_we1 = 1; b_addr1 = 19'h00002; b_wd1 = 16'h0002;
    push_b(0, 16'h0); push_b(0, 16'h0); push_b(0, 16'h0); push_b(1, 16'h0);
    b_req0 = 1; b_req1 = 1;
    for (int k = 0; k < 4; k++) begin
      wait_b(n);
      chk("fixed_gap", n, 4);
      if (k == 2) b_req0 = 0;
    end
    b_req1 = 0;
    a_force = 1;
    a_req0 = 1; a_we0 = 1; a_addr0 = 19'h00020; a_wd0 = 16'hC0DE;
    repeat (3) @(posedge clk);
    #1 chk("stall_on_status", {30'b0, a_cmd}, 0);
    a_force = 0;
    txn(0, 1, 19'h00020, 16'hC0DE, 16'hBEEF, 0, 3);
    a_req1 = 1; a_we1 = 0; a_addr1 = 19'h00004;
    @(posedge clk);
    @(posedge clk);
    #3 rst_n = 0;
    #1 chk_reset_outs();
    a_req1 = 0;
    @(posedge clk);
    #1 rst_n = 1;
    acks = 0;
    repeat (8) begin
      @(posedge clk); #1;
      if (a_ack0 || a_ack1) acks++;
    end
    chk("no_ack_after_reset", acks, 0);
    txn(1, 0, 19'h00004, 16'h0000, 16'h1234, 0, 4);
    txn(1, 1, 19'h00006, 16'h7777, 16'h1234, 0, 3);
    chk("timeout_seen_cleared", {31'b0, a_ts}, 0);
    repeat (2) @(posedge clk);
    chk("qa_drained", qa.size(), 0);
    chk("qb_drained", qb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
endmodule
